// File: rtl/axis_output_pipe_if.sv
// ---------------------------------------------------------------------------
// axis_output_pipe_if
// AXI-Stream bundle used on both sides of axis_output_pipe.
//   tvalid/tready : handshake
//   tlast         : end of packet
//   tuser         : sideband (USER_W bits)
//   tdata         : payload (DATA_W bits, word 0 in the LSBs)
//   tkeep         : byte enables (DATA_W/8 bits)
// The slave modport leaves tkeep out: the wide input side has no byte
// enables worth consuming, the pipe regenerates them on the output.
// ---------------------------------------------------------------------------
interface axis_output_pipe_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 4,
    parameter int KEEP_W = DATA_W / 8
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;

    modport master (output tvalid, tlast, tuser, tdata, tkeep, input tready);
    modport slave  (input  tvalid, tlast, tuser, tdata, output tready);
endinterface

// File: rtl/axis_output_pipe.sv
// ---------------------------------------------------------------------------
// axis_output_pipe
// Serializes one wide beat (S_WORDS words) from the conv engine into
// R = S_WORDS/M_WORDS narrow sub-beats (M_WORDS words), lowest word first.
// M_WORDS must divide S_WORDS and R must be at least 2.
//
// Ports:
//   aclk         : clock, rising edge
//   areset       : synchronous, active-high reset
//   s_axis       : wide input stream (slave modport)
//   m_axis       : narrow output stream (master modport), tkeep all ones
//   debug_config : {pkt_count, beat_count}, present only when
//                  AXIS_OUTPUT_PIPE_DEBUG_EN is defined
//
// The last sub-beat handshake can accept the next wide beat in the same
// cycle, so an unstalled stream emits one sub-beat every cycle.
// ---------------------------------------------------------------------------
module axis_output_pipe #(
    parameter int WORD_WIDTH  = 8,
    parameter int S_WORDS     = 64,
    parameter int M_WORDS     = 8,
    parameter int TUSER_WIDTH = 4
) (
    input  logic               aclk,
    input  logic               areset,
    axis_output_pipe_if.slave  s_axis,
    axis_output_pipe_if.master m_axis
`ifdef AXIS_OUTPUT_PIPE_DEBUG_EN
    ,
    output logic [31:0]        debug_config
`endif
);
    localparam int R        = S_WORDS / M_WORDS;
    localparam int CNT_W    = $clog2(R);
    localparam int S_DATA_W = WORD_WIDTH * S_WORDS;
    localparam int M_DATA_W = WORD_WIDTH * M_WORDS;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [S_DATA_W-1:0]     r_hold_data;
    logic [TUSER_WIDTH-1:0]  r_hold_user;
    logic                    r_hold_last;
    logic                    w_load;
    logic                    w_last_slice;
    logic                    w_s_rdy;
    logic                    w_s_hs;
    logic                    w_m_hs;

    assign w_last_slice = (r_cnt == CNT_W'(R - 1));
    // Ready depends only on state and downstream ready, never on s tvalid.
    assign w_s_rdy      = !areset && ((r_state == IDLE) || (w_last_slice && m_axis.tready));
    assign w_s_hs       = s_axis.tvalid && w_s_rdy;
    assign w_m_hs       = (r_state == SEND) && m_axis.tready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s_hs) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_m_hs) begin
                    if (!w_last_slice) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else if (w_s_hs) begin
                        // Reload on the final slice: no bubble between beats.
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_data <= '0;
            r_hold_user <= '0;
            r_hold_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_hold_data <= s_axis.tdata;
                r_hold_user <= s_axis.tuser;
                r_hold_last <= s_axis.tlast;
            end
        end
    end

    assign s_axis.tready = w_s_rdy;
    assign m_axis.tvalid = (r_state == SEND);
    assign m_axis.tdata  = r_hold_data[r_cnt*M_DATA_W +: M_DATA_W];
    assign m_axis.tlast  = r_hold_last && w_last_slice;
    assign m_axis.tuser  = r_hold_user;
    assign m_axis.tkeep  = '1;

`ifdef AXIS_OUTPUT_PIPE_DEBUG_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_beat_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_m_hs) begin
            if (m_axis.tlast) begin
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

    assign debug_config = {r_pkt_cnt, r_beat_cnt};
`endif
endmodule
